// File: rtl/game_pkg.sv
// Shared screen geometry, coordinate widths and blitter state encoding for the
// game-object datapaths and the sprite blitter.
package game_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    localparam int unsigned X_W = 8;
    localparam int unsigned Y_W = 7;
    localparam int unsigned C_W = 3;

    localparam logic [C_W-1:0] BG_COLOUR = 3'b000;

    typedef enum logic [1:0] {
        IDLE,
        ERASE,
        DRAW,
        DONE
    } blit_state_e;

endpackage

// File: rtl/sprite_blitter_rect_scanner.sv
// Column/row counter pair for one rectangle scan, plus base+offset adders that
// yield the coordinate of the pixel the counters will point at after this edge.
module rect_scanner
    import game_pkg::*;
#(
    parameter int unsigned DIM_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    input  logic [DIM_W-1:0] w,
    input  logic [DIM_W-1:0] h,
    input  logic [X_W-1:0]   base_x,
    input  logic [Y_W-1:0]   base_y,
    output logic             last,
    output logic [X_W:0]     px,
    output logic [Y_W:0]     py
);

    logic [DIM_W-1:0] col_q, col_d;
    logic [DIM_W-1:0] row_q, row_d;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear) begin
            col_d = '0;
            row_d = '0;
        end else if (advance) begin
            if (col_q == w - DIM_W'(1)) begin
                col_d = '0;
                row_d = row_q + DIM_W'(1);
            end else begin
                col_d = col_q + DIM_W'(1);
            end
        end
        // Sums carry one extra bit so an off-screen result stays detectable.
        px = {1'b0, base_x} + (X_W+1)'(col_d);
        py = {1'b0, base_y} + (Y_W+1)'(row_d);
    end

    assign last = (col_q == w - DIM_W'(1)) && (row_q == h - DIM_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// Rectangle draw/move requests -> single-pixel writes for the 160x120 VGA adapter.
// Optional build macro BLIT_CLIP_EN suppresses plots that fall off screen.
module sprite_blitter
    import game_pkg::*;
#(
    parameter int unsigned     DIM_W     = 6,
    parameter logic [C_W-1:0]  BG_COLOUR = game_pkg::BG_COLOUR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [X_W-1:0]   req_x,
    input  logic [Y_W-1:0]   req_y,
    input  logic [DIM_W-1:0] req_w,
    input  logic [DIM_W-1:0] req_h,
    input  logic [C_W-1:0]   req_colour,
    input  logic             req_move,
    input  logic [X_W-1:0]   req_old_x,
    input  logic [Y_W-1:0]   req_old_y,
    output logic [X_W-1:0]   x,
    output logic [Y_W-1:0]   y,
    output logic [C_W-1:0]   colour,
    output logic             plot,
    input  logic             plot_ready,
    output logic             done
);

    blit_state_e      state_q, state_d;
    logic             ready_q, ready_d;
    logic             plot_q, plot_d;
    logic             done_q, done_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [C_W-1:0]   colour_q, colour_d;

    logic [X_W-1:0]   new_x_q, new_x_d;
    logic [Y_W-1:0]   new_y_q, new_y_d;
    logic [X_W-1:0]   old_x_q, old_x_d;
    logic [Y_W-1:0]   old_y_q, old_y_d;
    logic [DIM_W-1:0] w_q, w_d;
    logic [DIM_W-1:0] h_q, h_d;
    logic [C_W-1:0]   draw_colour_q, draw_colour_d;

    logic             accept;
    logic             slot_done;
    logic             scan_clear;
    logic             scan_adv;
    logic             scan_last;
    logic [X_W-1:0]   base_x;
    logic [Y_W-1:0]   base_y;
    logic [X_W:0]     px;
    logic [Y_W:0]     py;
    logic             in_range;

    assign accept = req_valid && ready_q;

    // Scanner control is kept apart from the output datapath so the adders'
    // result never feeds back into the signals that steer them.
    always_comb begin
        slot_done  = 1'b0;
        scan_clear = 1'b0;
        scan_adv   = 1'b0;
        base_x     = (state_q == ERASE) ? old_x_q : new_x_q;
        base_y     = (state_q == ERASE) ? old_y_q : new_y_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    scan_clear = 1'b1;
                    base_x     = req_move ? req_old_x : req_x;
                    base_y     = req_move ? req_old_y : req_y;
                end
            end
            ERASE, DRAW: begin
                slot_done = !plot_q || plot_ready;
                if (slot_done) begin
                    if (scan_last) begin
                        scan_clear = 1'b1;
                        base_x     = new_x_q;
                        base_y     = new_y_q;
                    end else begin
                        scan_adv = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    rect_scanner #(
        .DIM_W (DIM_W)
    ) u_scanner (
        .clk     (clk),
        .reset   (reset),
        .clear   (scan_clear),
        .advance (scan_adv),
        .w       (w_q),
        .h       (h_q),
        .base_x  (base_x),
        .base_y  (base_y),
        .last    (scan_last),
        .px      (px),
        .py      (py)
    );

`ifdef BLIT_CLIP_EN
    assign in_range = (px < (X_W+1)'(SCREEN_W)) && (py < (Y_W+1)'(SCREEN_H));
`else
    logic unused_carry;
    assign unused_carry = px[X_W] ^ py[Y_W];
    assign in_range     = 1'b1;
`endif

    always_comb begin
        state_d       = state_q;
        ready_d       = ready_q;
        plot_d        = plot_q;
        done_d        = 1'b0;
        x_d           = x_q;
        y_d           = y_q;
        colour_d      = colour_q;
        new_x_d       = new_x_q;
        new_y_d       = new_y_q;
        old_x_d       = old_x_q;
        old_y_d       = old_y_q;
        w_d           = w_q;
        h_d           = h_q;
        draw_colour_d = draw_colour_q;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                plot_d  = 1'b0;
                if (accept) begin
                    new_x_d       = req_x;
                    new_y_d       = req_y;
                    old_x_d       = req_old_x;
                    old_y_d       = req_old_y;
                    w_d           = req_w;
                    h_d           = req_h;
                    draw_colour_d = req_colour;
                    ready_d       = 1'b0;
                    if ((req_w == '0) || (req_h == '0)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = req_move ? ERASE : DRAW;
                        colour_d = req_move ? BG_COLOUR : req_colour;
                        x_d      = px[X_W-1:0];
                        y_d      = py[Y_W-1:0];
                        plot_d   = in_range;
                    end
                end
            end
            ERASE: begin
                if (slot_done) begin
                    if (scan_last) begin
                        state_d  = DRAW;
                        colour_d = draw_colour_q;
                    end
                    x_d    = px[X_W-1:0];
                    y_d    = py[Y_W-1:0];
                    plot_d = in_range;
                end
            end
            DRAW: begin
                if (slot_done) begin
                    if (scan_last) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        plot_d  = 1'b0;
                    end else begin
                        x_d    = px[X_W-1:0];
                        y_d    = py[Y_W-1:0];
                        plot_d = in_range;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                ready_d = 1'b1;
                plot_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            ready_q       <= 1'b1;
            plot_q        <= 1'b0;
            done_q        <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            colour_q      <= '0;
            new_x_q       <= '0;
            new_y_q       <= '0;
            old_x_q       <= '0;
            old_y_q       <= '0;
            w_q           <= '0;
            h_q           <= '0;
            draw_colour_q <= '0;
        end else begin
            state_q       <= state_d;
            ready_q       <= ready_d;
            plot_q        <= plot_d;
            done_q        <= done_d;
            x_q           <= x_d;
            y_q           <= y_d;
            colour_q      <= colour_d;
            new_x_q       <= new_x_d;
            new_y_q       <= new_y_d;
            old_x_q       <= old_x_d;
            old_y_q       <= old_y_d;
            w_q           <= w_d;
            h_q           <= h_d;
            draw_colour_q <= draw_colour_d;
        end
    end

    assign req_ready = ready_q;
    assign plot      = plot_q;
    assign done      = done_q;
    assign x         = x_q;
    assign y         = y_q;
    assign colour    = colour_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: directed cases plus randomized
// requests against a pixel-list reference model (honours BLIT_CLIP_EN).
module tb_sprite_blitter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_x;
    logic [6:0] req_y;
    logic [5:0] req_w;
    logic [5:0] req_h;
    logic [2:0] req_colour;
    logic       req_move;
    logic [7:0] req_old_x;
    logic [6:0] req_old_y;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       plot_ready;
    logic       done;

    always #5 clk = ~clk;

    sprite_blitter dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_w      (req_w),
        .req_h      (req_h),
        .req_colour (req_colour),
        .req_move   (req_move),
        .req_old_x  (req_old_x),
        .req_old_y  (req_old_y),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .plot_ready (plot_ready),
        .done       (done)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
    } pix_t;

    pix_t exp_q[$];

    // Expected plots for one rectangle: raster order, wrapped or clipped.
    function automatic void add_rect(input int bx, input int by, input int w, input int h,
                                     input logic [2:0] c);
        for (int r = 0; r < h; r++) begin
            for (int cc = 0; cc < w; cc++) begin
                int sx;
                int sy;
                logic [7:0] tx;
                logic [6:0] ty;
                sx = bx + cc;
                sy = by + r;
                tx = sx[7:0];
                ty = sy[6:0];
`ifdef BLIT_CLIP_EN
                if (sx < 160 && sy < 120)
                    exp_q.push_back({tx, ty, c});
`else
                exp_q.push_back({tx, ty, c});
`endif
            end
        end
    endfunction

    // Issue one request from a negedge and follow it to the cycle after done.
    // bp_mode: 0 = plot_ready held high, 1 = random, 2 = 3-cycle stall at pixel 5.
    task automatic run_req(input logic [7:0] rx, input logic [6:0] ry,
                           input logic [5:0] rw, input logic [5:0] rh,
                           input logic [2:0] rc, input logic rm,
                           input logic [7:0] ox, input logic [6:0] oy,
                           input int bp_mode);
        int   slots;
        int   cyc;
        int   stalls;
        int   popped;
        int   stall_used;
        bit   got_done;
        bit   prev_hold;
        logic [18:0] prev;
        pix_t e;

        exp_q.delete();
        if (rm) add_rect(ox, oy, rw, rh, 3'b000);
        add_rect(rx, ry, rw, rh, rc);
        slots = (rm ? 2 : 1) * int'(rw) * int'(rh);

        check_eq("ready_before_req", req_ready, 1);
        req_valid  = 1'b1;
        req_x      = rx;
        req_y      = ry;
        req_w      = rw;
        req_h      = rh;
        req_colour = rc;
        req_move   = rm;
        req_old_x  = ox;
        req_old_y  = oy;
        plot_ready = 1'b1;
        @(negedge clk);
        req_valid  = 1'b0;
        req_x      = 8'($urandom);
        req_y      = 7'($urandom);
        req_w      = 6'($urandom);
        req_h      = 6'($urandom);
        req_colour = 3'($urandom);
        req_move   = 1'($urandom);
        req_old_x  = 8'($urandom);
        req_old_y  = 7'($urandom);
        check_eq("ready_low_after_accept", req_ready, 0);

        cyc = 1; stalls = 0; popped = 0; stall_used = 0;
        got_done = 1'b0; prev_hold = 1'b0; prev = '0;
        while (!got_done && cyc < 3000) begin
            if (prev_hold)
                check_eq("hold_stable", {plot, x, y, colour}, prev);
            case (bp_mode)
                1:       plot_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (plot && popped == 4 && stall_used < 3) begin
                        plot_ready = 1'b0;
                        stall_used++;
                    end else begin
                        plot_ready = 1'b1;
                    end
                end
                default: plot_ready = 1'b1;
            endcase
            prev_hold = 1'b0;
            if (done) begin
                got_done = 1'b1;
                check_eq("queue_empty_at_done", exp_q.size(), 0);
                check_eq("done_cycle", cyc, slots + stalls + 1);
                check_eq("no_plot_at_done", plot, 0);
            end else if (plot) begin
                if (plot_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("extra_plot", exp_q.size(), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("pixel", {x, y, colour}, e);
                        popped++;
                    end
                end else begin
                    stalls++;
                    prev_hold = 1'b1;
                    prev = {plot, x, y, colour};
                end
            end
            @(negedge clk);
            cyc++;
        end
        check_eq("done_seen", got_done, 1);
        check_eq("done_one_cycle", done, 0);
        check_eq("ready_after_done", req_ready, 1);
        plot_ready = 1'b1;
    endtask

    task automatic reset_mid_draw();
        int stray;
        req_valid  = 1'b1;
        req_x      = 8'd20;
        req_y      = 7'd30;
        req_w      = 6'd10;
        req_h      = 6'd1;
        req_colour = 3'b101;
        req_move   = 1'b0;
        plot_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("rst_px1", {plot, x}, {1'b1, 8'd20});
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_px3", {plot, x}, {1'b1, 8'd22});
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("rst_plot", plot, 0);
        check_eq("rst_ready", req_ready, 1);
        check_eq("rst_done", done, 0);
        check_eq("rst_xyc", {x, y, colour}, 18'd0);
        stray = 0;
        for (int i = 0; i < 15; i++) begin
            if (plot || done) stray++;
            @(negedge clk);
        end
        check_eq("rst_no_stray", stray, 0);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_x      = '0;
        req_y      = '0;
        req_w      = '0;
        req_h      = '0;
        req_colour = '0;
        req_move   = 1'b0;
        req_old_x  = '0;
        req_old_y  = '0;
        plot_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("reset_ready", req_ready, 1);
        check_eq("reset_plot", plot, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_x", x, 0);
        check_eq("reset_y", y, 0);
        check_eq("reset_colour", colour, 0);
        reset = 1'b0;
        @(negedge clk);

        run_req(8'd74, 7'd110, 6'd13, 6'd1, 3'b011, 1'b0, 8'd0, 7'd0, 0);
        run_req(8'd61, 7'd60, 6'd2, 6'd2, 3'b111, 1'b1, 8'd60, 7'd58, 0);
        run_req(8'd10, 7'd10, 6'd4, 6'd4, 3'b010, 1'b0, 8'd0, 7'd0, 2);
        run_req(8'd5, 7'd5, 6'd0, 6'd5, 3'b110, 1'b0, 8'd0, 7'd0, 0);
        run_req(8'd158, 7'd118, 6'd4, 6'd4, 3'b001, 1'b0, 8'd0, 7'd0, 0);
        run_req(8'd100, 7'd100, 6'd3, 6'd0, 3'b100, 1'b1, 8'd90, 7'd90, 0);
        reset_mid_draw();
        run_req(8'd40, 7'd50, 6'd3, 6'd2, 3'b101, 1'b0, 8'd0, 7'd0, 0);

        for (int i = 0; i < 40; i++) begin
            run_req(8'($urandom), 7'($urandom),
                    6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
                    3'($urandom), 1'($urandom),
                    8'($urandom), 7'($urandom),
                    int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
